// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
// Purpose: controller state encoding and 8N1 frame timing constants used by
//          uart_tx_arb and its round-robin picker.
// Ports:   none (package).

package uart_pkg;

  // Controller states: IDLE accepts a new grant, WAIT_BUSY holds start until
  // the transmitter reports it has taken the byte, WAIT_DONE waits for the
  // stop bit, GUARD stretches the line-idle time between frames.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GUARD     = 2'd3
  } arb_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int UART_FRAME_BITS = 10;

  // Shortest start-to-start period with continuous requests and no guard.
  localparam int UART_TX_PERIOD_MIN = 12;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rtl/uart_tx_arb_rr_pick.sv - combinational round-robin picker
// Purpose: choose the first pending request after the last served index,
//          wrapping modulo N_REQ.
// Ports:   i_req    - request vector
//          i_last   - index of the last requester served
//          o_valid  - at least one request pending
//          o_winner - index of the selected requester
//          o_onehot - one-hot form of o_winner (zero when o_valid is low)

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_last,
  output logic             o_valid,
  output logic [GW-1:0]    o_winner,
  output logic [N_REQ-1:0] o_onehot
);

  logic [GW-1:0] w_idx;

  // Walk the indices last+1, last+2, ... wrapping at N_REQ-1 so that
  // non-power-of-two requester counts wrap correctly. The first pending
  // index met on this walk wins; the last served index is checked last.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    o_onehot = '0;
    w_idx    = i_last;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_idx == GW'(N_REQ - 1)) begin
        w_idx = '0;
      end else begin
        w_idx = w_idx + GW'(1);
      end
      if (!o_valid && i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
    if (o_valid) begin
      o_onehot[o_winner] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one 8N1 UART transmitter
// Purpose: grants one pending requester byte at a time to a level-triggered
//          transmitter, sequences start/finish, then enforces a guard gap.
// Ports:   clk       - clock, one UART bit per cycle
//          rst       - asynchronous active-high reset
//          req       - per-requester level request, held until ack
//          req_data  - requester i byte on bits [8i+7:8i]
//          ack       - one-cycle one-hot pulse, byte captured
//          tx_start  - transmitter start
//          tx_data   - registered byte presented to the transmitter
//          tx_finish - transmitter idle / stop-bit flag
//          busy      - controller not in IDLE
//          grant_id  - index of the last requester served

module uart_tx_arb #(
  parameter int N_REQ     = 4,
  parameter int GUARD_CYC = 0,
  localparam int GW       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_finish,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  import uart_pkg::*;

  arb_state_t       r_state;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic [N_REQ-1:0] r_ack;
  logic             r_busy;
  logic [GW-1:0]    r_grant;
  logic [7:0]       r_guard;

  logic             w_valid;
  logic [GW-1:0]    w_winner;
  logic [N_REQ-1:0] w_onehot;
  logic [7:0]       w_bytes [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_bytes[k] = req_data[8*k +: 8];
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .i_req    (req),
    .i_last   (r_grant),
    .o_valid  (w_valid),
    .o_winner (w_winner),
    .o_onehot (w_onehot)
  );

  // A reset mid-frame lands in IDLE, where a grant still needs tx_finish=1;
  // a transmitter that is still shifting therefore blocks the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_grant    <= GW'(N_REQ - 1);
      r_guard    <= 8'd0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (tx_finish && w_valid) begin
            r_tx_data  <= w_bytes[w_winner];
            r_tx_start <= 1'b1;
            r_ack      <= w_onehot;
            r_grant    <= w_winner;
            r_busy     <= 1'b1;
            r_state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // finish dropping is the transmitter's proof it latched the byte
          if (!tx_finish) begin
            r_tx_start <= 1'b0;
            r_state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_finish) begin
            if (GUARD_CYC == 0) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_guard <= 8'(GUARD_CYC);
              r_state <= GUARD;
            end
          end
        end
        GUARD: begin
          // the cycle that sees a count of 1 is the last guard cycle
          if (r_guard <= 8'd1) begin
            r_guard <= 8'd0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_guard <= r_guard - 8'd1;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb with 8N1 transmitter model

module tb_uart_tx_arb;

  import uart_pkg::*;

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // main instance, GUARD_CYC = 0
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_finish;
  logic        busy;
  logic [1:0]  grant_id;

  // second instance, GUARD_CYC = 5
  logic [3:0]  req_g = '0;
  logic [31:0] data_g = '0;
  logic [3:0]  ack_g;
  logic        start_g;
  logic [7:0]  tdata_g;
  logic        fin_g;
  logic        busy_g;
  logic [1:0]  gid_g;

  uart_tx_arb #(.N_REQ(4), .GUARD_CYC(0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_finish(tx_finish),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arb #(.N_REQ(4), .GUARD_CYC(5)) u_dut_g5 (
    .clk(clk), .rst(rst), .req(req_g), .req_data(data_g), .ack(ack_g),
    .tx_start(start_g), .tx_data(tdata_g), .tx_finish(fin_g),
    .busy(busy_g), .grant_id(gid_g)
  );

  // transmitter models: latch on start, finish low from t1, stop bit at t10
  logic       m_busy = 1'b0, m_line = 1'b1, m_fin = 1'b1, force_low = 1'b0;
  logic [7:0] m_sh = '0;
  int         m_n = 0;
  assign tx_finish = m_fin & ~force_low;

  always @(posedge clk) begin
    if (!m_busy && tx_start) begin
      m_busy <= 1'b1; m_sh <= tx_data; m_line <= 1'b0; m_fin <= 1'b0; m_n <= 0;
    end else if (m_busy) begin
      if (m_n == 8) begin
        m_line <= 1'b1; m_fin <= 1'b1; m_busy <= 1'b0;
      end else begin
        m_line <= m_sh[m_n]; m_n <= m_n + 1;
      end
    end
  end

  logic mg_busy = 1'b0, mg_fin = 1'b1;
  int   mg_n = 0;
  assign fin_g = mg_fin;

  always @(posedge clk) begin
    if (!mg_busy && start_g) begin
      mg_busy <= 1'b1; mg_fin <= 1'b0; mg_n <= 0;
    end else if (mg_busy) begin
      if (mg_n == 8) begin
        mg_busy <= 1'b0; mg_fin <= 1'b1;
      end else begin
        mg_n <= mg_n + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // requester queues, scoreboards and logs
  logic [7:0] rq  [4][$];
  logic [7:0] rqg [4][$];
  exp_t       exp_q[$];
  exp_t       exp_g[$];
  logic [7:0] frame_q[$];
  int         rise_q[$];
  int         rise_g[$];
  int         ack_cyc_q[$];

  task automatic expect_byte(input int id, input logic [7:0] b);
    rq[id].push_back(b);
    exp_q.push_back('{id, b});
    frame_q.push_back(b);
  endtask

  // requesters: present the queue head, drop it the cycle after ack
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      if (ack_g[i] && rqg[i].size() != 0) void'(rqg[i].pop_front());
      req[i]              = (rq[i].size() != 0);
      req_data[8*i +: 8]  = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
      req_g[i]            = (rqg[i].size() != 0);
      data_g[8*i +: 8]    = (rqg[i].size() != 0) ? rqg[i][0] : 8'h00;
    end
  end

  // ack scoreboard monitors
  exp_t e0, e1;
  always @(negedge clk) begin
    if (!rst && ack != 0) begin
      ack_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", int'(ack), 0);
      end else begin
        e0 = exp_q.pop_front();
        chk("ack_onehot", int'(ack), 1 << e0.id);
        chk("ack_tx_data", int'(tx_data), int'(e0.b));
        chk("ack_grant_id", int'(grant_id), e0.id);
      end
    end
    if (!rst && ack_g != 0) begin
      if (exp_g.size() == 0) begin
        chk("g5_unexpected_ack", int'(ack_g), 0);
      end else begin
        e1 = exp_g.pop_front();
        chk("g5_ack_onehot", int'(ack_g), 1 << e1.id);
        chk("g5_tx_data", int'(tdata_g), int'(e1.b));
      end
    end
  end

  // tx_start monitors: never start on a busy transmitter, high exactly 2 cycles
  logic st_prev = 1'b0, sg_prev = 1'b0;
  int   st_len = 0;
  always @(negedge clk) begin
    if (tx_start && !st_prev) begin
      rise_q.push_back(cyc);
      chk("start_on_busy_tx", int'(m_busy), 0);
      st_len = 1;
    end else if (tx_start) begin
      st_len++;
    end else if (st_prev) begin
      chk("start_high_len", st_len, 2);
    end
    st_prev = tx_start;
    if (start_g && !sg_prev) rise_g.push_back(cyc);
    sg_prev = start_g;
  end

  // line monitor: rebuild each frame LSB first and check the stop bit
  logic       fm_on = 1'b0;
  int         fm_k = 0;
  logic [7:0] fm_b = '0;
  always @(negedge clk) begin
    if (!fm_on) begin
      if (!m_line) begin
        fm_on = 1'b1; fm_k = 0;
      end
    end else if (fm_k < UART_FRAME_BITS - 2) begin
      fm_b[fm_k] = m_line;
      fm_k++;
    end else begin
      fm_on = 1'b0;
      chk("stop_bit", int'(m_line), 1);
      if (frame_q.size() == 0) chk("unexpected_frame", int'(fm_b), -1);
      else chk("line_byte", int'(fm_b), int'(frame_q.pop_front()));
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || frame_q.size() != 0 || busy || m_busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, int'(n >= budget), 0);
  endtask

  task automatic wait_acks(input int cnt, input int budget, input string name);
    int n = 0;
    while (ack_cyc_q.size() < cnt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, int'(n >= budget), 0);
  endtask

  int n_g, rises_before, rel;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 8'h00);
    chk("rst_grant_id", int'(grant_id), 3);
    chk("rst_g5_grant_id", int'(gid_g), 3);
    rst = 1'b0;

    // single byte 0xA5 from requester 0
    expect_byte(0, 8'hA5);
    wait_idle(60, "t1_timeout");
    chk("t1_grant_id", int'(grant_id), 0);
    chk("t1_one_start", rise_q.size(), 1);

    // four requesters held high, requester 0 with a second byte
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("t2_rst_grant_id", int'(grant_id), 3);
    rise_q.delete();
    expect_byte(0, 8'h11);
    expect_byte(1, 8'h22);
    expect_byte(2, 8'h33);
    expect_byte(3, 8'h44);
    expect_byte(0, 8'h15);
    wait_idle(120, "t2_timeout");
    chk("t2_rise_count", rise_q.size(), 5);
    for (int i = 1; i < 5 && i < rise_q.size(); i++) chk("t2_period", rise_q[i] - rise_q[i-1], 12);

    // GUARD_CYC=5, back-to-back requests
    rqg[0].push_back(8'hC3); exp_g.push_back('{0, 8'hC3});
    rqg[1].push_back(8'h3C); exp_g.push_back('{1, 8'h3C});
    n_g = 0;
    while ((exp_g.size() != 0 || busy_g || mg_busy) && n_g < 100) begin
      @(posedge clk); #1;
      n_g++;
    end
    chk("t3_timeout", int'(n_g >= 100), 0);
    chk("t3_rise_count", rise_g.size(), 2);
    if (rise_g.size() == 2) chk("t3_guard_period", rise_g[1] - rise_g[0], 17);

    // req[2] rises during WAIT_DONE of requester 1's frame
    ack_cyc_q.delete();
    expect_byte(1, 8'h61);
    wait_acks(1, 20, "t4_first_ack_timeout");
    repeat (4) @(posedge clk);
    #1;
    chk("t4_in_wait_done", int'(busy && !tx_start), 1);
    expect_byte(2, 8'h72);
    wait_idle(60, "t4_timeout");
    chk("t4_ack_count", ack_cyc_q.size(), 2);
    if (ack_cyc_q.size() == 2) chk("t4_ack_spacing", ack_cyc_q[1] - ack_cyc_q[0], 12);

    // reset at t5 of a frame, released at t6
    ack_cyc_q.delete();
    expect_byte(3, 8'h3C);
    wait_acks(1, 20, "t5_ack_timeout");
    repeat (5) @(posedge clk);
    #1;
    chk("t5_pre_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_tx_start", int'(tx_start), 0);
    chk("t5_rst_ack", int'(ack), 0);
    chk("t5_rst_grant_id", int'(grant_id), 3);
    expect_byte(0, 8'h0A);
    expect_byte(1, 8'h1B);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle(80, "t5_timeout");

    // tx_finish held low with a request pending
    ack_cyc_q.delete();
    rises_before = rise_q.size();
    force_low = 1'b1;
    expect_byte(2, 8'h2F);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_ack", ack_cyc_q.size(), 0);
    chk("t6_no_start", rise_q.size() - rises_before, 0);
    chk("t6_req_pending", int'(req[2]), 1);
    @(posedge clk); #1;
    force_low = 1'b0;
    rel = cyc;
    wait_idle(40, "t6_timeout");
    chk("t6_ack_count", ack_cyc_q.size(), 1);
    if (ack_cyc_q.size() == 1) chk("t6_grant_latency", ack_cyc_q[0] - rel, 1);

    chk("end_exp_empty", exp_q.size() + exp_g.size(), 0);
    chk("end_frames_empty", frame_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin controller that shares one 8N1 UART transmitter among `N_REQ` byte-producing requesters. It sits between the requesters and the transmitter's level-triggered `start`/`data`/`finish` interface. Each cycle it selects at most one pending byte and sequences the transmitter through a complete frame. It then enforces a configurable idle gap before starting the next frame.

## Interface
- `N_REQ`, 4: number of requesters, legal range 2..16.
- `GUARD_CYC`, 0: extra idle cycles inserted after each frame completes, legal range 0..255.
- `clk` input 1: single clock; one UART bit per cycle.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input N_REQ: level request per requester; held high until acknowledged.
- `req_data` input 8*N_REQ: byte of requester i on bits [8i+7:8i].
- `ack` output N_REQ: one-cycle, one-hot pulse; the byte of that requester has been captured.
- `tx_start` output 1: drives the transmitter start input.
- `tx_data` output 8: registered byte presented to the transmitter.
- `tx_finish` input 1: transmitter finish flag; high = idle or stop bit.
- `busy` output 1: high whenever the controller state is not IDLE.
- `grant_id` output $clog2(N_REQ): index of the last requester served.

## Operation
- States:
  - IDLE
  - WAIT_BUSY
  - WAIT_DONE
  - GUARD
- IDLE: if `tx_finish`=1 and `req`≠0, pick the winner by round-robin.
  - Search starts at `grant_id`+1 and wraps modulo N_REQ.
  - On the same edge: `tx_data`<=winner byte, `tx_start`<=1, `ack[winner]`<=1 (one cycle), `grant_id`<=winner, go to WAIT_BUSY.
  - If `tx_finish`=0, or no request is pending, remain in IDLE with no action.
- WAIT_BUSY: hold `tx_start`=1 until `tx_finish`=0 is sampled.
  - On that edge: `tx_start`<=0, go to WAIT_DONE.
  - There is no timeout.
- WAIT_DONE: wait for `tx_finish`=1.
  - On that edge: go to GUARD and load the counter with GUARD_CYC.
  - If GUARD_CYC=0, go directly to IDLE instead.
- GUARD: decrement the counter each cycle; on reaching 1, go to IDLE.
- `tx_data` is stable from capture until the next capture.
- Requesters may change `req_data` or drop `req` on the cycle after `ack`.
- A requester that keeps `req` high is served again only when its turn comes.
- `req` going high in any non-IDLE state is not lost: it is considered at the next IDLE evaluation.
- Reset values:
  - state = IDLE
  - `tx_start` = 0
  - `tx_data` = 0x00
  - `ack` = 0
  - `busy` = 0
  - `grant_id` = N_REQ-1, so requester 0 has first priority
  - guard counter = 0
- Reset mid-frame: the controller returns to IDLE immediately. It does not issue a new start until `tx_finish`=1, so a transmitter still shifting a frame is never corrupted.
- `tx_finish`=0 after reset (transmitter still in its own reset) simply blocks grants.

## Timing
- Decision edge t0: `tx_start` and `ack` rise together.
- The transmitter latches the byte at t1, and `tx_finish` falls at t1.
- At t2 the controller samples `tx_finish`=0, so `tx_start` falls at t2 (high for exactly 2 cycles).
- Stop bit and `tx_finish`=1 appear at t10. The controller samples them at t11.
- Frame-to-frame period with continuous requests is 12+GUARD_CYC cycles from one `tx_start` rise to the next.
- Minimum line-idle (stop-bit) length is 3+GUARD_CYC cycles.
- Latency from `req` rise to `ack` is 1 cycle when IDLE and `tx_finish`=1.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, WAIT_BUSY, WAIT_DONE, GUARD)
  - constant UART_FRAME_BITS=10
  - constant UART_TX_PERIOD_MIN=12
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, last grant.
  - Outputs: valid, winner index, one-hot winner.
- `uart_tx_arb` holds all sequential state.

## Test plan
- Reset, then `req`=4'b0001 with byte 0xA5:
  - `ack[0]` pulses once, and `tx_start` is high for 2 cycles.
  - The line carries 0, 1,0,1,0,0,1,0,1, then 1 (LSB first).
  - `grant_id`=0.
- All four requesters held high with bytes 0x11/0x22/0x33/0x44:
  - Acks occur in order 0,1,2,3,0, with `tx_start` rises 12 cycles apart (GUARD_CYC=0).
- GUARD_CYC=5 with two back-to-back requests: the start-to-start spacing is 17 cycles.
- `req[2]` rises during WAIT_DONE of requester 1's frame: it is granted on the first IDLE cycle after the guard, and no ack is missed or duplicated.
- `rst` asserted at t5 of a frame and released at t6:
  - `tx_start`, `ack` and `busy` go to 0 immediately.
  - No new start occurs before the transmitter's `tx_finish` returns to 1.
  - The next grant goes to requester 0.
- `tx_finish` forced low with a pending request: no `ack` and no `tx_start` while it stays low; a grant occurs 1 cycle after `tx_finish` returns to 1.
